// File: rtl/expression_scheduler.sv
// Chooses the pet expression shown by the animation mux: latches event requests,
// arbitrates them by fixed priority, holds each expression and commits changes on frame boundaries.
module expression_scheduler #(
    parameter int TICK_DIV    = 100000,
    parameter int HOLD_TICKS  = 3000,
    parameter int SLEEP_TICKS = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       evt_play,
    input  logic       evt_feed,
    input  logic       evt_call,
    input  logic       frame_done,
    output logic [2:0] expr_sel,
    output logic [2:0] pending,
    output logic       switch_pulse
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam int IW = (SLEEP_TICKS > 0) ? $clog2(SLEEP_TICKS + 1) : 1;

    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_TICKS);
    localparam logic [HW-1:0] HOLD_PRE   = HW'(HOLD_TICKS - 1);
    localparam logic [IW-1:0] SLEEP_LAST = IW'(SLEEP_TICKS);

    localparam logic [2:0] EXPR_IDLE    = 3'd0;
    localparam logic [2:0] EXPR_HAPPY   = 3'd1;
    localparam logic [2:0] EXPR_SATISFY = 3'd2;
    localparam logic [2:0] EXPR_SLEEP   = 3'd3;
    localparam logic [2:0] EXPR_EXPECT  = 3'd4;

    typedef enum logic [1:0] {IDLE_S, SHOW_S, SLEEP_S} state_t;

    state_t          state, state_next;
    logic [TW-1:0]   tick_cnt;
    logic [HW-1:0]   hold_cnt;
    logic [IW-1:0]   idle_cnt;
    logic            expired;
    logic            tick;
    logic [2:0]      evt;
    logic [2:0]      win_expr;
    logic [2:0]      win_mask;
    logic            has_req;
    logic            has_target;
    logic            served;
    logic [2:0]      target;
    logic            commit;

    assign tick    = (tick_cnt == TICK_LAST);
    assign evt     = {evt_call, evt_feed, evt_play};
    assign has_req = (pending != 3'b000);
    assign commit  = frame_done & has_target;

    // Priority feed > play > call over the sticky {call, feed, play} flags.
    always_comb begin
        win_expr = EXPR_IDLE;
        win_mask = 3'b000;
        if (pending[1]) begin
            win_expr = EXPR_SATISFY;
            win_mask = 3'b010;
        end else if (pending[0]) begin
            win_expr = EXPR_HAPPY;
            win_mask = 3'b001;
        end else if (pending[2]) begin
            win_expr = EXPR_EXPECT;
            win_mask = 3'b100;
        end
    end

    always_comb begin
        has_target = 1'b0;
        served     = 1'b0;
        target     = expr_sel;
        case (state)
            IDLE_S: begin
                if (has_req) begin
                    has_target = 1'b1;
                    target     = win_expr;
                    served     = 1'b1;
                end else if (idle_cnt == SLEEP_LAST) begin
                    has_target = 1'b1;
                    target     = EXPR_SLEEP;
                end
            end
            SHOW_S: begin
                if (expired) begin
                    has_target = 1'b1;
                    target     = has_req ? win_expr : EXPR_IDLE;
                    served     = has_req;
                end
            end
            SLEEP_S: begin
                // Waking keeps the request pending so it is shown after EXPECT.
                if (has_req) begin
                    has_target = 1'b1;
                    target     = EXPR_EXPECT;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        if (commit) begin
            case (target)
                EXPR_IDLE:  state_next = IDLE_S;
                EXPR_SLEEP: state_next = SLEEP_S;
                default:    state_next = SHOW_S;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE_S;
            expr_sel     <= EXPR_IDLE;
            pending      <= 3'b000;
            switch_pulse <= 1'b0;
            tick_cnt     <= '0;
            hold_cnt     <= '0;
            idle_cnt     <= '0;
            expired      <= 1'b0;
        end else begin
            state        <= state_next;
            switch_pulse <= commit;
            tick_cnt     <= tick ? '0 : tick_cnt + 1'b1;
            if (commit) begin
                expr_sel <= target;
            end
            // A new pulse on the bit being served wins over its clear.
            pending <= (pending & ~((commit && served) ? win_mask : 3'b000)) | evt;

            if (commit) begin
                hold_cnt <= '0;
                expired  <= 1'b0;
            end else if (state == SHOW_S && tick && hold_cnt != HOLD_LAST) begin
                hold_cnt <= hold_cnt + 1'b1;
                if (hold_cnt == HOLD_PRE) begin
                    expired <= 1'b1;
                end
            end

            if (commit || (evt != 3'b000)) begin
                idle_cnt <= '0;
            end else if (state == IDLE_S && tick && idle_cnt != SLEEP_LAST) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end
endmodule

// File: doc/expression_scheduler.md
Name: expression_scheduler

Overview:
- Sequencer that decides which pet expression the animation controller displays: IDLE, HAPPY, SATISFY, SLEEP or EXPECT.
- Latches user/game event requests, arbitrates them by fixed priority, and holds each expression for a programmed time.
- Drops to SLEEP after inactivity.
- Commits every expression change only on an LCD frame boundary so the screen never tears mid-frame.
- Its expr_sel output replaces the single "go" step input of the animation mux.

Parameters:
- TICK_DIV, 100000, clk cycles per timer tick (1 ms at 100 MHz).
- HOLD_TICKS, 3000, ticks an event expression (HAPPY/SATISFY/EXPECT) is held.
- SLEEP_TICKS, 20000, ticks of inactivity in IDLE before SLEEP.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset (rst==0 resets on the clk edge).
- evt_play  in  1  one-cycle pulse; requests HAPPY.
- evt_feed  in  1  one-cycle pulse; requests SATISFY.
- evt_call  in  1  one-cycle pulse; requests EXPECT.
- frame_done  in  1  one-cycle pulse from the LCD path at the end of each full frame.
- expr_sel  out  3  committed expression: 0 IDLE, 1 HAPPY, 2 SATISFY, 3 SLEEP, 4 EXPECT.
- pending  out  3  sticky request flags {call, feed, play}.
- switch_pulse  out  1  high for one cycle in the cycle after expr_sel changes.

Behaviour:
- Reset (rst==0 at clk edge):
  - expr_sel=0, pending=0, switch_pulse=0.
  - Tick prescaler, hold counter and idle counter cleared; expired flag cleared.
  - Reset mid-hold or mid-sleep returns immediately to IDLE with no pending requests.
- Tick prescaler:
  - Free-running counter 0..TICK_DIV-1.
  - tick=1 for one cycle when it wraps.
  - Width $clog2(TICK_DIV).
- Request latch:
  - Each evt_* pulse sets its pending bit.
  - A bit clears in the cycle its request is committed.
  - Set and clear of the same bit in the same cycle: set wins, so the request is served again later.
  - Repeated pulses while a bit is pending merge into one request.
- Arbitration:
  - Fixed priority feed > play > call.
  - winner = highest pending bit.
- FSM, three states:
  - IDLE_S, expr_sel=0:
    - Idle counter increments on each tick.
    - If pending!=0, target = winner's expression.
    - Else, if idle count reached SLEEP_TICKS, target = SLEEP.
  - SHOW_S, expr_sel in {1,2,4}:
    - Hold counter increments on tick.
    - When it reaches HOLD_TICKS, the expired flag sets and stays set.
    - After expiry, target = winner's expression if pending!=0, else IDLE.
    - Requests arriving before expiry wait; no preemption.
  - SLEEP_S, expr_sel=3: any pending!=0 sets target = EXPECT (wake).
    - Wake does not clear pending; the waiting request is served after EXPECT's hold expires.
- Commit rule:
  - A target exists only when the conditions above hold.
  - A change is committed only on a cycle where frame_done=1 and a target exists.
  - Until frame_done arrives, the target keeps re-evaluating every cycle.
  - On commit: expr_sel <= target at that edge; the winner's pending bit clears if a request was served.
  - Hold counter and expired flag clear on every commit.
  - Idle counter clears on every commit and on any evt_* pulse.
  - switch_pulse=1 in the cycle after the commit edge, i.e. one cycle, coincident with the first cycle the new expr_sel is visible.
- Latency:
  - Event to expr_sel change is 1 cycle after the first frame_done following the event.
  - An event coincident with frame_done in IDLE_S is not committed on that frame_done; it waits for the next one.
- Committing the same expression as the current one (e.g. HAPPY→HAPPY after expiry with play pending) is legal: the hold restarts and switch_pulse still fires.
- Counters saturate at their terminal value; no wrap while waiting for frame_done.

Test Plan (TICK_DIV=4, HOLD_TICKS=5, SLEEP_TICKS=10, frame_done every 16 cycles):
- Release rst, no events -> expr_sel=0 for 40 cycles; the sleep threshold (10 ticks = 40 cycles) is reached, then expr_sel=3 one cycle after the next frame_done; switch_pulse one cycle.
- evt_feed pulse in IDLE -> pending=3'b010 until next frame_done; then expr_sel=2, pending=0; after 5 ticks plus next frame_done expr_sel=0.
- evt_play and evt_call in the same cycle -> expr_sel=1 (HAPPY) first; after expiry, next frame_done gives expr_sel=4; then 0.
- In SLEEP, evt_play -> expr_sel=4 at next frame_done with pending still 3'b001; after hold, expr_sel=1 and pending=0.
- evt_feed pulse in the same cycle feed is committed (second feed) -> pending bit stays 1; SATISFY is re-committed after expiry with switch_pulse=1 and expr_sel unchanged at 2.
- Drive rst=0 mid-SHOW with pending=3'b100 -> next edge expr_sel=0, pending=0, switch_pulse=0; with frame_done held low, expr_sel never changes.
